// File: rtl/cpu_pkg.sv
// Shared opcodes, ALU encodings, sequencer state
// and decoded-control bundle for the sequencer.
package cpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_LDI  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_XOR   = 2'b01;
  localparam logic [1:0] ALU_PASSB = 2'b10;
  localparam logic [1:0] ALU_SUB   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  typedef struct packed {
    logic       wr;
    logic       src;
    logic [1:0] op;
    logic       is_halt;
  } ctrl_t;

endpackage

// File: rtl/seq_decode.sv
// Opcode to control-bundle map; anything not
// listed decodes as a NOP (no write, ADD, reg B).
module seq_decode
  import cpu_pkg::*;
(
  input  logic [2:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      (opcode == OP_ADD): begin
        ctrl.wr = 1'b1;
        ctrl.op = ALU_ADD;
      end
      (opcode == OP_SUB): begin
        ctrl.wr = 1'b1;
        ctrl.op = ALU_SUB;
      end
      (opcode == OP_LDI): begin
        ctrl.wr  = 1'b1;
        ctrl.src = 1'b1;
        ctrl.op  = ALU_PASSB;
      end
      (opcode == OP_XOR): begin
        ctrl.wr = 1'b1;
        ctrl.op = ALU_XOR;
      end
      (opcode == OP_HALT): begin
        ctrl.is_halt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WB sequencer:
// owns pc, ir, retired count and reg_we.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic [INSTR_W-1:0] ir,
  output logic [1:0]         alu_op,
  output logic               alu_src,
  output logic               reg_we,
  output logic               busy,
  output logic               halted,
  output logic [PC_W-1:0]    pc,
  output logic [CNT_W-1:0]   retired
);

  state_t state, state_nxt;
  ctrl_t  dec, ctrl_q;

  seq_decode u_dec (
    .opcode (ir[INSTR_W-1 -: 3]),
    .ctrl   (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = dec.is_halt ? S_HALT
                                        : S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   if (start) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    reg_we   = 1'b0;
    alu_op   = ALU_ADD;
    alu_src  = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
      end
      S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy    = 1'b1;
        alu_op  = ctrl_q.op;
        alu_src = ctrl_q.src;
      end
      S_WB: begin
        busy    = 1'b1;
        alu_op  = ctrl_q.op;
        alu_src = ctrl_q.src;
        reg_we  = ctrl_q.wr;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
      ctrl_q  <= '0;
    end else begin
      unique case (state)
        S_FETCH:  if (imem_ack) ir <= imem_rdata;
        S_DECODE: ctrl_q <= dec;
        S_WB: begin
          pc <= pc + PC_W'(1);
          if (retired != '1)
            retired <= retired + CNT_W'(1);
        end
        S_HALT: if (start) begin
          pc      <= '0;
          retired <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench: stimulus queues expected writebacks,
// a monitor pops and compares them on every reg_we.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic [15:0] ir;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic        reg_we;
  logic        busy;
  logic        halted;
  logic [7:0]  pc;
  logic [15:0] retired;

  cpu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .ir         (ir),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .reg_we     (reg_we),
    .busy       (busy),
    .halted     (halted),
    .pc         (pc),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic       src;
    logic [7:0] pc;
  } wb_t;

  wb_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem [256];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        resp_ack = 1'b0;
  logic        inj_ack = 1'b0;

  assign imem_ack   = resp_ack | inj_ack;
  assign imem_rdata = resp_ack ? mem[imem_addr]
                               : 16'hFFFF;

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endfunction

  // imem model: ack after ack_delay wait cycles
  initial forever begin
    @(negedge clk);
    if (imem_req) begin
      if (wait_cnt >= ack_delay) begin
        resp_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        resp_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (reg_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_alu_op", alu_op, e.op);
        chk("wb_alu_src", alu_src, e.src);
        chk("wb_pc", pc, e.pc);
      end
    end
  end

  task automatic push(input logic [1:0] op,
                      input logic src,
                      input logic [7:0] p);
    wb_t e;
    e.op = op;
    e.src = src;
    e.pc = p;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_we(input int bound,
                         output int n,
                         output int nreq);
    n = 1;
    nreq = 0;
    while (!reg_we && n < bound) begin
      if (imem_req && imem_addr == 8'd0) nreq++;
      @(negedge clk);
      n++;
    end
    if (!reg_we) chk("we_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_halt(input int bound);
    int n = 0;
    while (!halted && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!halted) chk("halt_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation hung");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nreq;
    foreach (mem[i]) mem[i] = 16'h8000;

    // reset values
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_src", alu_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_retired", retired, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ADD, ack in first cycle -> 4 cycles
    mem[0] = 16'h0000;
    mem[1] = 16'hE000;
    push(2'b00, 1'b0, 8'd0);
    pulse_start();
    chk("t1_fetch_req", imem_req, 1);
    chk("t1_fetch_busy", busy, 1);
    wait_we(50, n, nreq);
    chk("t1_latency", n, 4);
    wait_halt(50);
    chk("t1_pc", pc, 1);
    chk("t1_retired", retired, 1);
    chk("t1_busy", busy, 0);

    // 2: LDI with 3 wait cycles -> 7 cycles
    mem[0] = 16'h4000;
    ack_delay = 3;
    push(2'b10, 1'b1, 8'd0);
    pulse_start();
    wait_we(50, n, nreq);
    chk("t2_latency", n, 7);
    chk("t2_req_cycles", nreq, 4);
    ack_delay = 0;
    wait_halt(50);
    chk("t2_pc", pc, 1);
    chk("t2_retired", retired, 1);

    // 3: SUB, XOR, NOP, HALT then restart
    mem[0] = 16'h2000;
    mem[1] = 16'h6000;
    mem[2] = 16'h8000;
    mem[3] = 16'hE000;
    push(2'b11, 1'b0, 8'd0);
    push(2'b01, 1'b0, 8'd1);
    pulse_start();
    wait_halt(80);
    chk("t3_halted", halted, 1);
    chk("t3_pc", pc, 3);
    chk("t3_retired", retired, 3);
    chk("t3_req_halt", imem_req, 0);
    push(2'b11, 1'b0, 8'd0);
    push(2'b01, 1'b0, 8'd1);
    pulse_start();
    chk("t3_restart_pc", pc, 0);
    chk("t3_restart_ret", retired, 0);
    wait_halt(80);
    chk("t3_pc2", pc, 3);

    // 4: NOP run up to pc=255, wrap to 0
    for (int i = 0; i < 255; i++) mem[i] = 16'h8000;
    mem[255] = 16'h0000;
    push(2'b00, 1'b0, 8'd255);
    pulse_start();
    wait_we(1200, n, nreq);
    @(negedge clk);
    chk("t4_wrap_pc", pc, 0);
    chk("t4_wrap_req", imem_req, 1);
    chk("t4_wrap_addr", imem_addr, 0);
    mem[0] = 16'hE000;
    wait_halt(50);
    chk("t4_retired", retired, 256);

    // 5: ack in DECODE, start in EXECUTE
    mem[0] = 16'h6000;
    mem[1] = 16'hE000;
    push(2'b01, 1'b0, 8'd0);
    pulse_start();
    @(negedge clk);
    inj_ack = 1'b1;
    @(negedge clk);
    inj_ack = 1'b0;
    chk("t5_ir_exec", ir, 16'h6000);
    chk("t5_exec_op", alu_op, 2'b01);
    chk("t5_exec_we", reg_we, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_wb_we", reg_we, 1);
    @(negedge clk);
    chk("t5_ir_kept", ir, 16'h6000);
    chk("t5_fetch_addr", imem_addr, 1);
    chk("t5_fetch_req", imem_req, 1);
    wait_halt(50);
    chk("t5_pc", pc, 1);

    // 6: reset mid-fetch
    mem[0] = 16'h0000;
    ack_delay = 5;
    pulse_start();
    chk("t6_req_pre", imem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_req", imem_req, 0);
    chk("t6_pc", pc, 0);
    chk("t6_busy", busy, 0);
    chk("t6_halted", halted, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    repeat (6) @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    chk("t6_retired", retired, 0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
